gpio_int_status_ctrl: RTL

//  Downstream consumer of the CDC pulse stage. Captures single-cycle clk_cpu interrupt pulses
//  (error/inform/shake) into sticky pending bits. Applies per-bit masks and drives one level IRQ per class.

---
 rtl/gpio_int_status_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/gpio_int_status_ctrl.sv
// gpio_int_status_ctrl: sticky interrupt pending/mask bank for the error,
// inform and shake pulse classes, with first-error capture, a saturating
// error-event counter and a word-addressed CPU register port.
module gpio_int_status_ctrl #(
  parameter int ERR_W = 42,
  parameter int INF_W = 50,
  parameter int SK_W  = 15
) (
  input  logic             clk_cpu,
  input  logic             rstn_cpu,
  input  logic [ERR_W-1:0] error_int_cpu,
  input  logic [INF_W-1:0] inform_int_cpu,
  input  logic [SK_W-1:0]  shake_int_cpu,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic [3:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             reg_rvld,
  output logic             irq_err,
  output logic             irq_inf,
  output logic             irq_sk
);

  // Index of the lowest set bit; scanning downwards leaves the lowest one last.
  function automatic logic [5:0] lowest_set(input logic [ERR_W-1:0] vec);
    logic [5:0] idx;
    idx = 6'd0;
    for (int i = ERR_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 6'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [ERR_W-1:0] err_pend_r, err_mask_r, err_pend_nxt_s, err_mask_nxt_s, err_clr_s;
  logic [INF_W-1:0] inf_pend_r, inf_mask_r, inf_pend_nxt_s, inf_mask_nxt_s, inf_clr_s;
  logic [SK_W-1:0]  sk_pend_r, sk_mask_r, sk_pend_nxt_s, sk_mask_nxt_s, sk_clr_s;
  logic             first_vld_r, first_vld_nxt_s, first_clr_s;
  logic [5:0]       first_idx_r, first_idx_nxt_s;
  logic [15:0]      err_cnt_r, err_cnt_nxt_s;
  logic [31:0]      rd_mux_s;

  // Decode register writes into W1C clear vectors and new mask values.
  always_comb begin
    err_clr_s      = '0;
    inf_clr_s      = '0;
    sk_clr_s       = '0;
    err_mask_nxt_s = err_mask_r;
    inf_mask_nxt_s = inf_mask_r;
    sk_mask_nxt_s  = sk_mask_r;
    first_clr_s    = 1'b0;
    if (reg_wr) begin
      case (reg_addr)
        4'd0:    err_clr_s      = ERR_W'(reg_wdata);
        4'd1:    err_clr_s      = ERR_W'({reg_wdata, 32'd0});
        4'd2:    err_mask_nxt_s = {err_mask_r[ERR_W-1:32], reg_wdata};
        4'd3:    err_mask_nxt_s = {reg_wdata[ERR_W-33:0], err_mask_r[31:0]};
        4'd4:    inf_clr_s      = INF_W'(reg_wdata);
        4'd5:    inf_clr_s      = INF_W'({reg_wdata, 32'd0});
        4'd6:    inf_mask_nxt_s = {inf_mask_r[INF_W-1:32], reg_wdata};
        4'd7:    inf_mask_nxt_s = {reg_wdata[INF_W-33:0], inf_mask_r[31:0]};
        4'd8:    sk_clr_s       = reg_wdata[SK_W-1:0];
        4'd9:    sk_mask_nxt_s  = reg_wdata[SK_W-1:0];
        4'd10:   first_clr_s    = reg_wdata[31];
        default: first_clr_s    = 1'b0;
      endcase
    end else begin
      first_clr_s = 1'b0;
    end
  end

  // Pending bits: clear first, then OR in new pulses so a same-cycle pulse wins.
  always_comb begin
    err_pend_nxt_s = (err_pend_r & ~err_clr_s) | error_int_cpu;
    inf_pend_nxt_s = (inf_pend_r & ~inf_clr_s) | inform_int_cpu;
    sk_pend_nxt_s  = (sk_pend_r  & ~sk_clr_s)  | shake_int_cpu;
  end

  // First-error capture and saturating error-event counter next state.
  always_comb begin
    first_vld_nxt_s = first_vld_r;
    first_idx_nxt_s = first_idx_r;
    if (first_vld_r && !first_clr_s) begin
      first_vld_nxt_s = 1'b1;
      first_idx_nxt_s = first_idx_r;
    end else if (|error_int_cpu) begin
      first_vld_nxt_s = 1'b1;
      first_idx_nxt_s = lowest_set(error_int_cpu);
    end else begin
      first_vld_nxt_s = 1'b0;
      first_idx_nxt_s = 6'd0;
    end

    err_cnt_nxt_s = err_cnt_r;
    if (reg_wr && (reg_addr == 4'd11)) begin
      err_cnt_nxt_s = 16'd0;
    end else if ((|error_int_cpu) && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_nxt_s = err_cnt_r + 16'd1;
    end else begin
      err_cnt_nxt_s = err_cnt_r;
    end
  end

  // Read multiplexer over the current (pre-write) register contents.
  always_comb begin
    rd_mux_s = 32'd0;
    case (reg_addr)
      4'd0:    rd_mux_s = err_pend_r[31:0];
      4'd1:    rd_mux_s = 32'(err_pend_r[ERR_W-1:32]);
      4'd2:    rd_mux_s = err_mask_r[31:0];
      4'd3:    rd_mux_s = 32'(err_mask_r[ERR_W-1:32]);
      4'd4:    rd_mux_s = inf_pend_r[31:0];
      4'd5:    rd_mux_s = 32'(inf_pend_r[INF_W-1:32]);
      4'd6:    rd_mux_s = inf_mask_r[31:0];
      4'd7:    rd_mux_s = 32'(inf_mask_r[INF_W-1:32]);
      4'd8:    rd_mux_s = 32'(sk_pend_r);
      4'd9:    rd_mux_s = 32'(sk_mask_r);
      4'd10:   rd_mux_s = {first_vld_r, 25'd0, first_idx_r};
      4'd11:   rd_mux_s = {16'd0, err_cnt_r};
      default: rd_mux_s = 32'd0;
    endcase
  end

  // State registers; masks come out of reset fully masked.
  always_ff @(posedge clk_cpu or negedge rstn_cpu) begin
    if (!rstn_cpu) begin
      err_pend_r  <= '0;
      inf_pend_r  <= '0;
      sk_pend_r   <= '0;
      err_mask_r  <= '1;
      inf_mask_r  <= '1;
      sk_mask_r   <= '1;
      first_vld_r <= 1'b0;
      first_idx_r <= 6'd0;
      err_cnt_r   <= 16'd0;
    end else begin
      err_pend_r  <= err_pend_nxt_s;
      inf_pend_r  <= inf_pend_nxt_s;
      sk_pend_r   <= sk_pend_nxt_s;
      err_mask_r  <= err_mask_nxt_s;
      inf_mask_r  <= inf_mask_nxt_s;
      sk_mask_r   <= sk_mask_nxt_s;
      first_vld_r <= first_vld_nxt_s;
      first_idx_r <= first_idx_nxt_s;
      err_cnt_r   <= err_cnt_nxt_s;
    end
  end

  // Registered outputs: one-cycle read response and level IRQs from current state.
  always_ff @(posedge clk_cpu or negedge rstn_cpu) begin
    if (!rstn_cpu) begin
      reg_rdata <= 32'd0;
      reg_rvld  <= 1'b0;
      irq_err   <= 1'b0;
      irq_inf   <= 1'b0;
      irq_sk    <= 1'b0;
    end else begin
      reg_rdata <= reg_rd ? rd_mux_s : 32'd0;
      reg_rvld  <= reg_rd;
      irq_err   <= |(err_pend_r & ~err_mask_r);
      irq_inf   <= |(inf_pend_r & ~inf_mask_r);
      irq_sk    <= |(sk_pend_r & ~sk_mask_r);
    end
  end

endmodule
